mux_16x1_rr: RTL

- 16-to-1 collecting multiplexer: the return path for the 1x16 demultiplexer.
- Sixteen independent lanes each offer a DATA_W-bit word with a valid/ready handshake.
- A round-robin arbiter picks one lane per transfer and loads a registered output stage.
- The output carries the word plus the 4-bit lane index, so a downstream 1x16 demux can steer it back using the same sel encoding.

---
 rtl/mux_16x1_rr_if.sv | 33 +++
 rtl/mux_16x1_rr.sv | 77 +++++++
 2 files changed

// File: rtl/mux_16x1_rr_if.sv
// Lane-side and output-side handshake bundle for the 16-to-1 round-robin collector.
// The master modport is the environment; the slave modport is the mux itself.
interface mux_16x1_rr_if #(
    parameter int unsigned DATA_W = 8
);
    logic [16*DATA_W-1:0] in_data;
    logic [15:0]          in_valid;
    logic [15:0]          in_ready;
    logic [DATA_W-1:0]    out_data;
    logic [3:0]           out_sel;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_sel,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_sel,
        output out_valid
    );
endinterface

// File: rtl/mux_16x1_rr.sv
// 16-to-1 collecting mux: round-robin arbitration over sixteen valid/ready lanes
// into a registered output stage that tags each word with its source lane index.
module mux_16x1_rr #(
    parameter int unsigned DATA_W = 8
) (
    input logic           clk,
    input logic           rst,
    mux_16x1_rr_if.slave  bus
);
    logic [3:0]        ptr_q, ptr_d;
    logic [3:0]        grant;
    logic [3:0]        idx;
    logic              found;
    logic              any_valid;
    logic              load;
    logic [DATA_W-1:0] data_q, data_d;
    logic [3:0]        sel_q, sel_d;
    logic              valid_q, valid_d;

    // Search starts at ptr and wraps; 4-bit index arithmetic gives the mod-16 wrap.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < 16; k++) begin
            idx = ptr_q + 4'(k);
            if (!found && bus.in_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign any_valid = |bus.in_valid;
    assign load      = ~valid_q | bus.out_ready;

    // Held low during reset so no lane believes its word was taken.
    always_comb begin
        bus.in_ready = '0;
        if (!rst && load && any_valid) begin
            bus.in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        if (load) begin
            valid_d = any_valid;
            if (any_valid) begin
                data_d = bus.in_data[grant*DATA_W +: DATA_W];
                sel_d  = grant;
                ptr_d  = grant + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = valid_q;
endmodule
